// File: rtl/tusca_pkg.sv
// ============================================================================
//  Module      : tusca_pkg
//  Description : Shared definitions for the tusca_uc control unit: state
//                encodings, db_estado / error-counter widths, default
//                parameter values, command bundle and helper functions.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package tusca_pkg;

    localparam int ESTADO_W           = 4;
    localparam int ERROS_W            = 8;
    localparam int TIMEOUT_CICLOS_DEF = 50_000_000;
    localparam int MAX_TENTATIVAS_DEF = 3;

    typedef enum logic [ESTADO_W-1:0] {
        INICIAL          = 4'd0,
        PREPARA          = 4'd1,
        ESPERA_DELAY     = 4'd2,
        MEDE             = 4'd3,
        ESPERA_MEDIDA    = 4'd4,
        TRANSMITE        = 4'd5,
        ESPERA_TRANSMITE = 4'd6,
        CONFIG           = 4'd7,
        ESPERA_CONFIG    = 4'd8,
        ERRO             = 4'd9
    } estado_t;

    // Datapath command bundle, one bit per command output.
    typedef struct packed {
        logic zera_delay;
        logic conta_delay;
        logic medir_dht11;
        logic receber_config;
        logic transmite_medida;
        logic gira;
    } cmd_t;

    // Moore decode: commands depend only on the state.
    function automatic cmd_t decodifica(input estado_t e);
        cmd_t c;
        c      = '0;
        c.gira = (e != INICIAL);
        case (e)
            PREPARA:      c.zera_delay       = 1'b1;
            ESPERA_DELAY: c.conta_delay      = 1'b1;
            MEDE:         c.medir_dht11      = 1'b1;
            TRANSMITE:    c.transmite_medida = 1'b1;
            CONFIG:       c.receber_config   = 1'b1;
            default:      ;
        endcase
        return c;
    endfunction

    // Saturating increment for the error counter.
    function automatic logic [ERROS_W-1:0] inc_sat(input logic [ERROS_W-1:0] v);
        return (v == {ERROS_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uc_timeout.sv
// ============================================================================
//  Module      : uc_timeout
//  Description : Timeout counter for the ESPERA_* wait states. Counts while
//                'conta' is high, holds at its terminal value, and flags
//                'fim' once TIMEOUT_CICLOS-1 counted cycles have elapsed.
//  Ports       : clock, reset (async, active-high)
//                zera  - clear the count (has priority over conta)
//                conta - count enable
//                fim   - terminal count reached while counting
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uc_timeout
    import tusca_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic zera,
    input  logic conta,
    output logic fim
);

    localparam int CNT_W = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
    localparam logic [CNT_W-1:0] ULTIMO = CNT_W'(TIMEOUT_CICLOS - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (zera) begin
            cnt <= '0;
        end else if (conta && !fim) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Gated with conta so a stale terminal value never leaks out of a wait.
    assign fim = conta && (cnt == ULTIMO);

endmodule

`default_nettype wire

// File: rtl/tusca_uc.sv
// ============================================================================
//  Module      : tusca_uc
//  Description : Moore control unit for the periodic DHT11 measurement /
//                transmission / configuration cycle. Commands are registered
//                copies of the decode of the next state, so outputs never
//                depend combinationally on inputs.
//  Ports       : clock, reset (async, active-high)
//                iniciar, parar, configurar           - operator controls
//                fim_delay, pronto_medida, erro_medida,
//                pronto_config, erro_config,
//                pronto_transmite_medida              - datapath status
//                zera_delay, conta_delay, medir_dht11,
//                receber_config, transmite_medida,
//                gira                                 - datapath commands
//                falha_medida   - sticky: last measurement cycle failed
//                contagem_erros - saturating error count
//                db_estado      - current state code
//  Options     : TUSCA_UC_RETRY_EN - retry failed measurements up to
//                MAX_TENTATIVAS times before reporting a failure.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tusca_uc
    import tusca_pkg::*;
#(
    parameter int TIMEOUT_CICLOS = TIMEOUT_CICLOS_DEF,
    parameter int MAX_TENTATIVAS = MAX_TENTATIVAS_DEF
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                parar,
    input  logic                configurar,
    input  logic                fim_delay,
    input  logic                pronto_medida,
    input  logic                erro_medida,
    input  logic                pronto_config,
    input  logic                erro_config,
    input  logic                pronto_transmite_medida,
    output logic                zera_delay,
    output logic                conta_delay,
    output logic                medir_dht11,
    output logic                receber_config,
    output logic                transmite_medida,
    output logic                gira,
    output logic                falha_medida,
    output logic [ERROS_W-1:0]  contagem_erros,
    output logic [ESTADO_W-1:0] db_estado
);

    if (MAX_TENTATIVAS < 1) begin : g_chk_max_tentativas
        $error("tusca_uc: MAX_TENTATIVAS must be at least 1");
    end

    estado_t            state, next_state;
    cmd_t               cmd_q, cmd_d;
    logic               pedido_config, pedido_d;
    logic               falha_q, falha_d;
    logic [ERROS_W-1:0] erros_q, erros_d;
    logic               pend;
    logic               espera;
    logic               tmo_fim;

`ifdef TUSCA_UC_RETRY_EN
    localparam int TENT_W = $clog2(MAX_TENTATIVAS + 1);
    logic [TENT_W-1:0] tent_q, tent_d;
`endif

    // The timeout counter runs only in the three status waits and is held
    // at zero everywhere else, so it is always zero on entry.
    assign espera = (state == ESPERA_MEDIDA) || (state == ESPERA_TRANSMITE) ||
                    (state == ESPERA_CONFIG);

    uc_timeout #(
        .TIMEOUT_CICLOS (TIMEOUT_CICLOS)
    ) u_timeout (
        .clock (clock),
        .reset (reset),
        .zera  (!espera),
        .conta (espera),
        .fim   (tmo_fim)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= INICIAL;
            cmd_q         <= '0;
            pedido_config <= 1'b0;
            falha_q       <= 1'b0;
            erros_q       <= '0;
`ifdef TUSCA_UC_RETRY_EN
            tent_q        <= '0;
`endif
        end else begin
            state         <= next_state;
            cmd_q         <= cmd_d;
            pedido_config <= pedido_d;
            falha_q       <= falha_d;
            erros_q       <= erros_d;
`ifdef TUSCA_UC_RETRY_EN
            tent_q        <= tent_d;
`endif
        end
    end

    always_comb begin
        next_state = state;
        pedido_d   = pedido_config;
        falha_d    = falha_q;
        erros_d    = erros_q;
`ifdef TUSCA_UC_RETRY_EN
        tent_d     = tent_q;
`endif
        // A request arriving this cycle is already honoured, so a pulse in
        // PREPARA/ESPERA_DELAY diverts straight to CONFIG.
        pend = (state != INICIAL) && (pedido_config || configurar);
        if (configurar && (state != INICIAL)) begin
            pedido_d = 1'b1;
        end

        if (parar) begin
            next_state = INICIAL;
        end else begin
            case (state)
                INICIAL:          if (iniciar) next_state = PREPARA;
                PREPARA:          next_state = pend ? CONFIG : ESPERA_DELAY;
                ESPERA_DELAY: begin
                    if (pend)           next_state = CONFIG;
                    else if (fim_delay) next_state = MEDE;
                end
                MEDE:             next_state = ESPERA_MEDIDA;
                TRANSMITE:        next_state = ESPERA_TRANSMITE;
                CONFIG:           next_state = ESPERA_CONFIG;
                ESPERA_MEDIDA: begin
                    if (erro_medida) begin
                        next_state = ERRO;
                    end else if (pronto_medida) begin
                        next_state = TRANSMITE;
                        falha_d    = 1'b0;
`ifdef TUSCA_UC_RETRY_EN
                        tent_d     = '0;
`endif
                    end else if (tmo_fim) begin
                        next_state = ERRO;
                    end
                end
                ESPERA_TRANSMITE: begin
                    if (pronto_transmite_medida || tmo_fim) next_state = PREPARA;
                end
                ESPERA_CONFIG: begin
                    if (erro_config) begin
                        next_state = PREPARA;
                        erros_d    = inc_sat(erros_q);
                    end else if (pronto_config || tmo_fim) begin
                        next_state = PREPARA;
                    end
                end
                ERRO: begin
`ifdef TUSCA_UC_RETRY_EN
                    if (tent_q < TENT_W'(MAX_TENTATIVAS)) begin
                        next_state = MEDE;
                        tent_d     = tent_q + 1'b1;
                    end else begin
                        next_state = PREPARA;
                        falha_d    = 1'b1;
                        erros_d    = inc_sat(erros_q);
                        tent_d     = '0;
                    end
`else
                    next_state = PREPARA;
                    falha_d    = 1'b1;
                    erros_d    = inc_sat(erros_q);
`endif
                end
                default:          next_state = INICIAL;
            endcase
        end

        if (parar || (next_state == CONFIG)) begin
            pedido_d = 1'b0;
        end

        cmd_d = decodifica(next_state);
    end

    assign zera_delay       = cmd_q.zera_delay;
    assign conta_delay      = cmd_q.conta_delay;
    assign medir_dht11      = cmd_q.medir_dht11;
    assign receber_config   = cmd_q.receber_config;
    assign transmite_medida = cmd_q.transmite_medida;
    assign gira             = cmd_q.gira;
    assign falha_medida     = falha_q;
    assign contagem_erros   = erros_q;
    assign db_estado        = state;

endmodule

`default_nettype wire
